dmem_access_ctrl: RTL and testbench

- Single data-memory port shared between the MEM stage (loads/stores) and an external master (loader/debug DMA).
- Arbitrates the two requesters and drives a variable-latency memory handshake.
- Stalls the pipeline until a CPU access completes, then presents load data on RD, which feeds the MEM/WB register.
- Sits between the EX/MEM register outputs and the data memory.

---
 rtl/dmem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory port controller: arbitrates MEM-stage loads/stores against an external master.
// Define DMEM_TIMEOUT_EN to abort accesses whose MemAck never arrives and flag MemErr.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic              StallMem,
    output logic [DATA_W-1:0] RD,
    input  logic              ExtReq,
    input  logic              ExtWe,
    input  logic [ADDR_W-1:0] ExtAddr,
    input  logic [DATA_W-1:0] ExtWData,
    output logic              ExtAck,
    output logic [DATA_W-1:0] ExtRData,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    output logic              MemErr
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] StarveLimit = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StCpuBusy,
        StExtBusy,
        StCpuDone,
        StExtDone
    } stateT;

    stateT             stateQ, stateD;
    logic              memReqQ, memReqD;
    logic              memWeQ, memWeD;
    logic [ADDR_W-1:0] memAddrQ, memAddrD;
    logic [DATA_W-1:0] memWDataQ, memWDataD;
    logic [DATA_W-1:0] rdQ, rdD;
    logic [DATA_W-1:0] extRDataQ, extRDataD;
    logic [SW-1:0]     starveQ, starveD;
    logic              cpuAcc;
    logic              busy;
    logic              timedOut;
    logic [DATA_W-1:0] respData;

    assign cpuAcc = MemReadM | MemWriteM;
    assign busy   = (stateQ == StCpuBusy) || (stateQ == StExtBusy);

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] AbortData = DATA_W'(32'hDEADBEEF);

    logic [TW-1:0] timerQ;
    logic          errQ;

    assign timedOut = busy && !MemAck && (timerQ == TW'(TIMEOUT - 1));
    assign respData = MemAck ? MemRData : AbortData;
    assign MemErr   = errQ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timerQ <= '0;
            errQ   <= 1'b0;
        end else begin
            if (busy && !MemAck && !timedOut) begin
                timerQ <= timerQ + TW'(1);
            end else begin
                timerQ <= '0;
            end
            if (timedOut) begin
                errQ <= 1'b1;
            end
        end
    end
`else
    assign timedOut = 1'b0;
    assign respData = MemRData;
    assign MemErr   = 1'b0;
`endif

    always_comb begin
        stateD    = stateQ;
        memReqD   = memReqQ;
        memWeD    = memWeQ;
        memAddrD  = memAddrQ;
        memWDataD = memWDataQ;
        rdD       = rdQ;
        extRDataD = extRDataQ;
        starveD   = starveQ;

        unique case (stateQ)
            StIdle: begin
                // CPU wins unless the external master has been passed over STARVE_MAX times
                if (cpuAcc && !(ExtReq && (starveQ == StarveLimit))) begin
                    stateD    = StCpuBusy;
                    memReqD   = 1'b1;
                    memWeD    = MemWriteM;
                    memAddrD  = ALUResultM;
                    memWDataD = WriteDataM;
                    starveD   = ExtReq ? starveQ + SW'(1) : '0;
                end else if (ExtReq) begin
                    stateD    = StExtBusy;
                    memReqD   = 1'b1;
                    memWeD    = ExtWe;
                    memAddrD  = ExtAddr;
                    memWDataD = ExtWData;
                    starveD   = '0;
                end else begin
                    starveD = '0;
                end
            end
            StCpuBusy, StExtBusy: begin
                if (MemAck || timedOut) begin
                    memReqD = 1'b0;
                    memWeD  = 1'b0;
                    if (stateQ == StCpuBusy) begin
                        stateD = StCpuDone;
                        if (!memWeQ) begin
                            rdD = respData;
                        end
                    end else begin
                        stateD    = StExtDone;
                        extRDataD = respData;
                    end
                end
            end
            StCpuDone, StExtDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ    <= StIdle;
            memReqQ   <= 1'b0;
            memWeQ    <= 1'b0;
            memAddrQ  <= '0;
            memWDataQ <= '0;
            rdQ       <= '0;
            extRDataQ <= '0;
            starveQ   <= '0;
        end else begin
            stateQ    <= stateD;
            memReqQ   <= memReqD;
            memWeQ    <= memWeD;
            memAddrQ  <= memAddrD;
            memWDataQ <= memWDataD;
            rdQ       <= rdD;
            extRDataQ <= extRDataD;
            starveQ   <= starveD;
        end
    end

    // Stall drops only in CPU_DONE so the pipeline advances exactly once per access
    assign StallMem = cpuAcc & (stateQ != StCpuDone);
    assign ExtAck   = (stateQ == StExtDone);
    assign RD       = rdQ;
    assign ExtRData = extRDataQ;
    assign MemReq   = memReqQ;
    assign MemWe    = memWeQ;
    assign MemAddr  = memAddrQ;
    assign MemWData = memWDataQ;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: scoreboarded CPU/ext accesses against a memory responder.
// Timeout/abort checks run only when DMEM_TIMEOUT_EN is defined.
module tb_dmem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        StallMem;
    logic [31:0] RD;
    logic        ExtReq, ExtWe;
    logic [31:0] ExtAddr, ExtWData;
    logic        ExtAck;
    logic [31:0] ExtRData;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData, MemRData;
    logic        MemAck;
    logic        MemErr;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] cpuQ[$];
    logic [31:0] extQ[$];
    int          ackDelay = 1;
    bit          respEn = 1'b1;
    int          lateReq = 0;
    int          lateAck = 0;
    int          reqCnt = 0;
    logic [31:0] mem[logic [31:0]];

    dmem_access_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .StallMem  (StallMem),
        .RD        (RD),
        .ExtReq    (ExtReq),
        .ExtWe     (ExtWe),
        .ExtAddr   (ExtAddr),
        .ExtWData  (ExtWData),
        .ExtAck    (ExtAck),
        .ExtRData  (ExtRData),
        .MemReq    (MemReq),
        .MemWe     (MemWe),
        .MemAddr   (MemAddr),
        .MemWData  (MemWData),
        .MemRData  (MemRData),
        .MemAck    (MemAck),
        .MemErr    (MemErr)
    );

    always #5 CLK = ~CLK;

    // Memory model: acks ackDelay cycles after the first cycle MemReq is seen high
    initial begin : responder
        mem[32'h40]  = 32'h1234_5678;
        mem[32'h200] = 32'hCAFE_F00D;
        MemAck   = 1'b0;
        MemRData = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            MemAck = 1'b0;
            if (lateReq != lateAck) begin
                lateAck  = lateReq;
                MemAck   = 1'b1;
                MemRData = 32'hFFFF_FFFF;
                reqCnt   = 0;
            end else if (respEn && MemReq === 1'b1) begin
                reqCnt++;
                if (reqCnt == ackDelay + 1) begin
                    MemAck = 1'b1;
                    reqCnt = 0;
                    if (MemWe === 1'b1) begin
                        mem[MemAddr] = MemWData;
                        MemRData     = 32'h0;
                    end else begin
                        MemRData = mem.exists(MemAddr) ? mem[MemAddr] : 32'h0;
                    end
                end
            end else begin
                reqCnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic extCheck(input string tag);
        logic [31:0] exp;
        check({tag, " ext queue depth"}, 32'(extQ.size()), 32'd1);
        if (extQ.size() != 0) begin
            exp = extQ.pop_front();
            check({tag, " ExtRData"}, ExtRData, exp);
        end
        ExtReq = 1'b0;
    endtask

    task automatic cpuAccess(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int delay, input logic ext,
                             input int expStall, input logic [31:0] expRd,
                             input bit busCheck, input string tag);
        int          n = 0;
        logic [31:0] exp;
        @(negedge CLK);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = addr;
        WriteDataM = wdata;
        ExtReq     = ext;
        ackDelay   = delay;
        cpuQ.push_back(expRd);
        #1;
        while (StallMem === 1'b1 && n < 100) begin
            n++;
            if (ExtAck === 1'b1) begin
                extCheck(tag);
            end
            if (busCheck && MemReq === 1'b1) begin
                check({tag, " MemAddr"}, MemAddr, addr);
                check({tag, " MemWe"}, 32'(MemWe), 32'(wr));
                if (wr) check({tag, " MemWData"}, MemWData, wdata);
            end
            @(negedge CLK);
        end
        check({tag, " stall cycles"}, 32'(n), 32'(expStall));
        exp = cpuQ.pop_front();
        check({tag, " RD"}, RD, exp);
        check({tag, " MemReq low in done"}, 32'(MemReq), 32'd0);
    endtask

    task automatic waitExt(input int expCycles, input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge CLK);
            n++;
            if (ExtAck === 1'b1) begin
                extCheck(tag);
                seen = 1'b1;
            end
        end
        check({tag, " ext latency"}, 32'(n), 32'(expCycles));
    endtask

    initial begin
        RST        = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUResultM = 32'h0;
        WriteDataM = 32'h0;
        ExtReq     = 1'b0;
        ExtWe      = 1'b0;
        ExtAddr    = 32'h0;
        ExtWData   = 32'h0;
        repeat (2) @(negedge CLK);
        check("reset MemReq", 32'(MemReq), 32'd0);
        check("reset MemWe", 32'(MemWe), 32'd0);
        check("reset MemAddr", MemAddr, 32'h0);
        check("reset MemWData", MemWData, 32'h0);
        check("reset RD", RD, 32'h0);
        check("reset ExtAck", 32'(ExtAck), 32'd0);
        check("reset ExtRData", ExtRData, 32'h0);
        check("reset MemErr", 32'(MemErr), 32'd0);
        check("reset StallMem", 32'(StallMem), 32'd0);
        RST = 1'b0;

        cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 2, 1'b0, 4, 32'h1234_5678, 1'b1, "load");
        MemReadM = 1'b0;
        cpuAccess(1'b0, 1'b1, 32'h100, 32'hA5A5_A5A5, 1, 1'b0, 3, 32'h1234_5678, 1'b1, "store");
        MemWriteM = 1'b0;
        cpuAccess(1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b0, 3, 32'hA5A5_A5A5, 1'b1, "loadback");
        MemReadM = 1'b0;

        // Starvation: ext held through four CPU grants, fifth load waits behind the ext access
        ExtWe   = 1'b0;
        ExtAddr = 32'h200;
        extQ.push_back(32'hCAFE_F00D);
        for (int i = 0; i < 4; i++) begin
            cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b1, 3, 32'h1234_5678, 1'b0, "starve cpu");
        end
        cpuAccess(1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 7, 32'hA5A5_A5A5, 1'b0, "starve ext");
        MemReadM = 1'b0;
        check("starve ExtReq dropped", 32'(ExtReq), 32'd0);

        // Simultaneous request: CPU first, ext granted in the IDLE right after CPU_DONE
        ExtAddr = 32'h100;
        extQ.push_back(32'hA5A5_A5A5);
        cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b1, 3, 32'h1234_5678, 1'b1, "simul");
        MemReadM = 1'b0;
        waitExt(4, "simul");
        @(negedge CLK);
        check("ExtAck single pulse", 32'(ExtAck), 32'd0);
        check("ExtRData held", ExtRData, 32'hA5A5_A5A5);

        // External write, then a CPU load reads it back
        ExtWe    = 1'b1;
        ExtAddr  = 32'h300;
        ExtWData = 32'h0BAD_F00D;
        extQ.push_back(32'h0);
        ExtReq = 1'b1;
        waitExt(3, "ext write");
        ExtWe = 1'b0;
        cpuAccess(1'b1, 1'b0, 32'h300, 32'h0, 1, 1'b0, 3, 32'h0BAD_F00D, 1'b1, "ext readback");
        MemReadM = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        respEn = 1'b0;
        cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b0, 17, 32'hDEAD_BEEF, 1'b1, "timeout");
        MemReadM = 1'b0;
        respEn   = 1'b1;
        check("timeout MemErr set", 32'(MemErr), 32'd1);
        cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b0, 3, 32'h1234_5678, 1'b1, "post timeout");
        MemReadM = 1'b0;
        check("timeout MemErr sticky", 32'(MemErr), 32'd1);
`else
        check("MemErr tied low", 32'(MemErr), 32'd0);
`endif

        // Reset during CPU_BUSY, then a stray MemAck while IDLE
        respEn = 1'b0;
        @(negedge CLK);
        MemReadM   = 1'b1;
        ALUResultM = 32'h40;
        repeat (2) @(negedge CLK);
        check("rst busy MemReq", 32'(MemReq), 32'd1);
        RST      = 1'b1;
        MemReadM = 1'b0;
        #1;
        check("rst async MemReq", 32'(MemReq), 32'd0);
        check("rst async MemAddr", MemAddr, 32'h0);
        check("rst async RD", RD, 32'h0);
        check("rst async ExtRData", ExtRData, 32'h0);
        check("rst async MemErr", 32'(MemErr), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        lateReq++;
        repeat (2) @(negedge CLK);
        check("late ack MemReq", 32'(MemReq), 32'd0);
        check("late ack RD", RD, 32'h0);
        check("late ack ExtAck", 32'(ExtAck), 32'd0);
        check("late ack StallMem", 32'(StallMem), 32'd0);
        respEn = 1'b1;
        cpuAccess(1'b1, 1'b0, 32'h40, 32'h0, 1, 1'b0, 3, 32'h1234_5678, 1'b1, "recover");
        MemReadM = 1'b0;
        repeat (2) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
